// File: rtl/multicycle_control_unit_if.sv
// Handshake and control bundle between the multi-cycle control unit and the datapath.
// The Trap line exists only when MCU_ILLEGAL_TRAP_EN is defined.
interface multicycle_control_unit_if #(
    parameter int unsigned OPCODE_W = 3
);
    logic [OPCODE_W-1:0] OPCODE;
    logic                MemReady;
    logic                InstrRead;
    logic                IRWrite;
    logic                PCWrite;
    logic                RegDst;
    logic                ALUSrc;
    logic                MemToReg;
    logic                RegWrite;
    logic                MemRead;
    logic                MemWrite;
    logic                Branch;
    logic                MulRegWrite;
    logic [1:0]          ALUOp;
    logic                MulStart;
    logic [2:0]          State;
`ifdef MCU_ILLEGAL_TRAP_EN
    logic                Trap;
`endif

`ifdef MCU_ILLEGAL_TRAP_EN
    // Control unit side
    modport master (
        input  OPCODE, MemReady,
        output InstrRead, IRWrite, PCWrite, RegDst, ALUSrc, MemToReg, RegWrite,
               MemRead, MemWrite, Branch, MulRegWrite, ALUOp, MulStart, State, Trap
    );
    // Datapath / instruction register side
    modport slave (
        output OPCODE, MemReady,
        input  InstrRead, IRWrite, PCWrite, RegDst, ALUSrc, MemToReg, RegWrite,
               MemRead, MemWrite, Branch, MulRegWrite, ALUOp, MulStart, State, Trap
    );
`else
    // Control unit side
    modport master (
        input  OPCODE, MemReady,
        output InstrRead, IRWrite, PCWrite, RegDst, ALUSrc, MemToReg, RegWrite,
               MemRead, MemWrite, Branch, MulRegWrite, ALUOp, MulStart, State
    );
    // Datapath / instruction register side
    modport slave (
        output OPCODE, MemReady,
        input  InstrRead, IRWrite, PCWrite, RegDst, ALUSrc, MemToReg, RegWrite,
               MemRead, MemWrite, Branch, MulRegWrite, ALUOp, MulStart, State
    );
`endif
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencing control unit: FETCH -> DECODE -> EXEC -> MEM -> WB.
// Outputs are Moore-decoded from the state register, the latched opcode and the MUL
// down-counter; only IRWrite/PCWrite see MemReady (in FETCH). All outputs are forced
// to 0 while Reset is high.
// Optional feature macro: MCU_ILLEGAL_TRAP_EN (illegal opcodes park in TRAP until Reset;
// without it an illegal opcode is executed as a 2-cycle NOP).
module multicycle_control_unit #(
    parameter int unsigned OPCODE_W    = 3,
    parameter int unsigned MUL_LATENCY = 4
) (
    input logic                        Clock,
    input logic                        Reset,
    multicycle_control_unit_if.master  bus
);

    localparam int unsigned CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LATENCY - 1);

    localparam logic [2:0] OpLw   = 3'b000;
    localparam logic [2:0] OpSw   = 3'b001;
    localparam logic [2:0] OpMul  = 3'b010;
    localparam logic [2:0] OpBeq  = 3'b011;
    localparam logic [2:0] OpAddi = 3'b100;
    localparam logic [2:0] OpSlli = 3'b101;
    localparam logic [2:0] OpR    = 3'b111;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
`ifdef MCU_ILLEGAL_TRAP_EN
        StWb     = 3'd4,
        StTrap   = 3'd5
`else
        StWb     = 3'd4
`endif
    } state_e;

    state_e              state_q;
    logic [OPCODE_W-1:0] op_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2:0]          op3;

    assign op3 = op_q[2:0];

    // Legal opcodes have zero upper bits and are not 110.
    function automatic logic is_legal(input logic [OPCODE_W-1:0] op);
        is_legal = ((op >> 3) == '0) && (op[2:0] != 3'b110);
    endfunction

    // Sequencer: state, opcode latch and MUL latency down-counter.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= StFetch;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                StFetch: begin
                    if (bus.MemReady) state_q <= StDecode;
                end
                StDecode: begin
                    op_q  <= bus.OPCODE;
                    cnt_q <= CNT_INIT;
                    if (is_legal(bus.OPCODE)) begin
                        state_q <= StExec;
                    end else begin
`ifdef MCU_ILLEGAL_TRAP_EN
                        state_q <= StTrap;
`else
                        state_q <= StFetch;
`endif
                    end
                end
                StExec: begin
                    case (op3)
                        OpMul: begin
                            if (cnt_q == '0) state_q <= StWb;
                            else             cnt_q   <= cnt_q - CNT_W'(1);
                        end
                        OpLw, OpSw: state_q <= StMem;
                        OpBeq:      state_q <= StFetch;
                        default:    state_q <= StWb;
                    endcase
                end
                StMem: begin
                    if (bus.MemReady) state_q <= (op3 == OpLw) ? StWb : StFetch;
                end
                StWb: state_q <= StFetch;
`ifdef MCU_ILLEGAL_TRAP_EN
                StTrap: state_q <= StTrap;
`endif
                default: state_q <= StFetch;
            endcase
        end
    end

    // Moore output decode; Reset blanks every output.
    always_comb begin
        bus.InstrRead   = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.PCWrite     = 1'b0;
        bus.RegDst      = 1'b0;
        bus.ALUSrc      = 1'b0;
        bus.MemToReg    = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.Branch      = 1'b0;
        bus.MulRegWrite = 1'b0;
        bus.ALUOp       = 2'b00;
        bus.MulStart    = 1'b0;
        bus.State       = 3'd0;
`ifdef MCU_ILLEGAL_TRAP_EN
        bus.Trap        = 1'b0;
`endif
        if (!Reset) begin
            bus.State = state_q;
            case (state_q)
                StFetch: begin
                    bus.InstrRead = 1'b1;
                    bus.IRWrite   = bus.MemReady;
                    bus.PCWrite   = bus.MemReady;
                end
                StExec: begin
                    case (op3)
                        OpR: begin
                            bus.ALUOp  = 2'b10;
                            bus.RegDst = 1'b1;
                        end
                        OpAddi: bus.ALUSrc = 1'b1;
                        OpSlli: begin
                            bus.ALUSrc = 1'b1;
                            bus.ALUOp  = 2'b11;
                        end
                        OpLw, OpSw: bus.ALUSrc = 1'b1;
                        OpBeq: begin
                            bus.ALUOp  = 2'b01;
                            bus.Branch = 1'b1;
                        end
                        OpMul: begin
                            bus.ALUOp    = 2'b10;
                            // Counter sits at its load value only on the first EXEC cycle.
                            bus.MulStart = (cnt_q == CNT_INIT);
                        end
                        default: ;
                    endcase
                end
                StMem: begin
                    bus.ALUSrc   = 1'b1;
                    bus.MemRead  = (op3 == OpLw);
                    bus.MemWrite = (op3 == OpSw);
                end
                StWb: begin
                    case (op3)
                        OpR, OpAddi, OpSlli: bus.RegWrite = 1'b1;
                        OpLw: begin
                            bus.RegWrite = 1'b1;
                            bus.MemToReg = 1'b1;
                        end
                        OpMul:   bus.MulRegWrite = 1'b1;
                        default: ;
                    endcase
                end
`ifdef MCU_ILLEGAL_TRAP_EN
                StTrap: bus.Trap = 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule
